// File: rtl/mc_seq_pkg.sv
// Shared types and opcode constants for the multi-cycle instruction sequencer.
package mc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU_R  = 3'd0,
        CLS_ALU_I  = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } opclass_e;

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic is_mem_class(input opclass_e cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Control/handshake bundle between the sequencer (master) and its datapath (slave).
interface mc_sequencer_if;

    logic        run;
    logic [6:0]  opcode;
    logic        br_taken;
    logic        mem_ack;
    logic        ir_we;
    logic        pc_we;
    logic        pc_src;
    logic        ru_we;
    logic        mem_req;
    logic        dm_we;
    logic        instr_done;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instr_count;

    modport master (
        input  run, opcode, br_taken, mem_ack,
        output ir_we, pc_we, pc_src, ru_we, mem_req, dm_we,
               instr_done, illegal, state, instr_count
    );

    modport slave (
        output run, opcode, br_taken, mem_ack,
        input  ir_we, pc_we, pc_src, ru_we, mem_req, dm_we,
               instr_done, illegal, state, instr_count
    );

endinterface

// File: rtl/mc_seq_opclass.sv
// Combinational opcode classifier: maps opcode[6:0] to an op class plus a valid flag.
module mc_seq_opclass
    import mc_seq_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_e   cls,
    output logic       valid
);

    always_comb begin
        cls   = CLS_ALU_R;
        valid = 1'b1;
        case (opcode)
            OP_ALU_R:  cls = CLS_ALU_R;
            OP_ALU_I:  cls = CLS_ALU_I;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control sequencer.
// Define MC_SEQ_PERF_CNT_EN to build the retired-instruction counter.
module mc_sequencer
    import mc_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mc_sequencer_if.master bus
);

    state_e   state_q;
    opclass_e cls_q;
    opclass_e dec_cls;
    logic     dec_valid;

    logic ir_we_q;
    logic mem_req_q;
    logic dm_we_q;
    logic wb_q;
    logic br_q;
    logic illegal_q;
    logic retire;

    mc_seq_opclass u_opclass (
        .opcode (bus.opcode),
        .cls    (dec_cls),
        .valid  (dec_valid)
    );

    // Moore strobes are registered alongside the transition into their state;
    // only the store-completion and branch-direction terms are decoded live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= CLS_ALU_R;
            ir_we_q   <= 1'b0;
            mem_req_q <= 1'b0;
            dm_we_q   <= 1'b0;
            wb_q      <= 1'b0;
            br_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ir_we_q   <= 1'b0;
            mem_req_q <= 1'b0;
            dm_we_q   <= 1'b0;
            wb_q      <= 1'b0;
            br_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.run) begin
                        state_q <= S_FETCH;
                        ir_we_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (dec_valid) begin
                        cls_q   <= dec_cls;
                        br_q    <= (dec_cls == CLS_BRANCH);
                        state_q <= S_EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (is_mem_class(cls_q)) begin
                        state_q   <= S_MEM;
                        mem_req_q <= 1'b1;
                        dm_we_q   <= (cls_q == CLS_STORE);
                    end else if (cls_q == CLS_BRANCH) begin
                        state_q <= bus.run ? S_FETCH : S_IDLE;
                        ir_we_q <= bus.run;
                    end else begin
                        state_q <= S_WB;
                        wb_q    <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (!bus.mem_ack) begin
                        mem_req_q <= 1'b1;
                        dm_we_q   <= (cls_q == CLS_STORE);
                    end else if (cls_q == CLS_STORE) begin
                        state_q <= bus.run ? S_FETCH : S_IDLE;
                        ir_we_q <= bus.run;
                    end else begin
                        state_q <= S_WB;
                        wb_q    <= 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= bus.run ? S_FETCH : S_IDLE;
                    ir_we_q <= bus.run;
                end
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // dm_we_q is only ever set while a store sits in MEM.
    assign retire = wb_q | br_q | (dm_we_q & bus.mem_ack);

    assign bus.ir_we      = ir_we_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.dm_we      = dm_we_q;
    assign bus.ru_we      = wb_q;
    assign bus.pc_we      = retire;
    assign bus.pc_src     = br_q & bus.br_taken;
    assign bus.instr_done = retire;
    assign bus.illegal    = illegal_q;
    assign bus.state      = state_q;

`ifdef MC_SEQ_PERF_CNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign bus.instr_count = count_q;
`else
    assign bus.instr_count = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed self-checking bench: per-instruction expected cycle sequences built from the latency rules.
module tb_mc_sequencer;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir_we;
        logic        pc_we;
        logic        pc_src;
        logic        ru_we;
        logic        mem_req;
        logic        dm_we;
        logic        done;
        logic        illegal;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    mc_sequencer_if bus ();

    mc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          fetch_cyc = 0;
    int          last_lat = 0;
    int          memreq_cyc = 0;
    logic [31:0] model_cnt = '0;
    exp_t        expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: actual %0h required %0h", name, cyc, act, req);
        end
    endtask

    // Opcode kinds: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 unsupported
    function automatic int kind(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011: return 0;
            7'b0000011:             return 1;
            7'b0100011:             return 2;
            7'b1100011:             return 3;
            default:                return 4;
        endcase
    endfunction

    function automatic exp_t rec(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        e.ir_we = (st == 3'd1);
        e.illegal = (st == 3'd6);
        return e;
    endfunction

    task automatic step(input logic r, input logic [6:0] op, input logic ack,
                        input logic bt, input exp_t e_in);
        exp_t e;
        e = e_in;
        @(posedge clk);
        #1;
        bus.run = r;
        bus.opcode = op;
        bus.mem_ack = ack;
        bus.br_taken = bt;
`ifdef MC_SEQ_PERF_CNT_EN
        e.cnt = model_cnt;
`else
        e.cnt = '0;
`endif
        if (e.done) model_cnt = model_cnt + 32'd1;
        expq.push_back(e);
    endtask

    task automatic idle_step(input logic r);
        step(r, 7'b0, 1'b0, 1'b0, rec(3'd0));
    endtask

    // One instruction from FETCH; run is ra from DECODE on; abort_mem>0 stops after that many MEM cycles.
    task automatic instr(input logic [6:0] op, input int unsigned w, input logic bt,
                         input logic ra, input int unsigned abort_mem);
        int   k;
        exp_t e;
        k = kind(op);
        step(1'b1, op, 1'b0, bt, rec(3'd1));
        step(ra, op, 1'b0, bt, rec(3'd2));
        if (k == 4) return;
        e = rec(3'd3);
        if (k == 3) begin
            e.pc_we = 1'b1;
            e.pc_src = bt;
            e.done = 1'b1;
            step(ra, op, 1'b1, bt, e);
            return;
        end
        step(ra, op, 1'b1, bt, e);
        if (k == 0) begin
            e = rec(3'd5);
            e.ru_we = 1'b1;
            e.pc_we = 1'b1;
            e.done = 1'b1;
            step(ra, op, 1'b0, bt, e);
            return;
        end
        for (int unsigned i = 0; i <= w; i++) begin
            if (abort_mem != 0 && i == abort_mem) return;
            e = rec(3'd4);
            e.mem_req = 1'b1;
            e.dm_we = (k == 2);
            if (i == w && k == 2) begin
                e.pc_we = 1'b1;
                e.done = 1'b1;
            end
            step(ra, op, (i == w), bt, e);
        end
        if (k == 1) begin
            e = rec(3'd5);
            e.ru_we = 1'b1;
            e.pc_we = 1'b1;
            e.done = 1'b1;
            step(ra, op, 1'b0, bt, e);
        end
    endtask

    task automatic check_lat(input string name, input int req);
        @(negedge clk);
        #1;
        chk(name, last_lat, req);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_state"}, bus.state, 3'd0);
        chk({tag, "_ir_we"}, bus.ir_we, 1'b0);
        chk({tag, "_pc_we"}, bus.pc_we, 1'b0);
        chk({tag, "_mem_req"}, bus.mem_req, 1'b0);
        chk({tag, "_dm_we"}, bus.dm_we, 1'b0);
        chk({tag, "_done"}, bus.instr_done, 1'b0);
        chk({tag, "_illegal"}, bus.illegal, 1'b0);
        chk({tag, "_count"}, bus.instr_count, 32'd0);
    endtask

    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.ir_we === 1'b1) fetch_cyc = cyc;
            if (bus.instr_done === 1'b1) last_lat = cyc - fetch_cyc + 1;
            if (bus.mem_req === 1'b1) memreq_cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("state", bus.state, e.st);
                chk("ir_we", bus.ir_we, e.ir_we);
                chk("pc_we", bus.pc_we, e.pc_we);
                chk("pc_src", bus.pc_src, e.pc_src);
                chk("ru_we", bus.ru_we, e.ru_we);
                chk("mem_req", bus.mem_req, e.mem_req);
                chk("dm_we", bus.dm_we, e.dm_we);
                chk("instr_done", bus.instr_done, e.done);
                chk("illegal", bus.illegal, e.illegal);
                chk("instr_count", bus.instr_count, e.cnt);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin : stimulus
        rst_n = 1'b1;
        bus.run = 1'b0;
        bus.opcode = 7'b0;
        bus.mem_ack = 1'b0;
        bus.br_taken = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_state("rst0");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        idle_step(1'b0);
        idle_step(1'b1);
        instr(7'b0110011, 0, 1'b0, 1'b1, 0);
        check_lat("lat_alu_r", 4);
        instr(7'b0010011, 0, 1'b1, 1'b1, 0);
        check_lat("lat_alu_i", 4);
        memreq_cyc = 0;
        instr(7'b0000011, 3, 1'b0, 1'b1, 0);
        check_lat("lat_load_w3", 8);
        chk("load_memreq_cycles", memreq_cyc, 4);
        memreq_cyc = 0;
        instr(7'b0100011, 0, 1'b0, 1'b1, 0);
        check_lat("lat_store_w0", 4);
        chk("store_memreq_cycles", memreq_cyc, 1);
        instr(7'b0100011, 2, 1'b1, 1'b1, 0);
        check_lat("lat_store_w2", 6);
        instr(7'b1100011, 0, 1'b1, 1'b1, 0);
        check_lat("lat_branch_t", 3);
        instr(7'b1100011, 0, 1'b0, 1'b1, 0);
        check_lat("lat_branch_nt", 3);

        instr(7'b0110011, 0, 1'b0, 1'b0, 0);
        idle_step(1'b0);
        @(negedge clk);
        #1;
        chk("run_drop_state", bus.state, 3'd0);
`ifdef MC_SEQ_PERF_CNT_EN
        chk("run_drop_count", bus.instr_count, 32'd8);
`else
        chk("run_drop_count", bus.instr_count, 32'd0);
`endif

        // Reset while a load waits in MEM with mem_req high.
        idle_step(1'b1);
        instr(7'b0000011, 5, 1'b0, 1'b1, 2);
        @(negedge clk);
        #2;
        chk("pre_reset_mem_req", bus.mem_req, 1'b1);
        rst_n = 1'b0;
        #1 check_reset_state("rst_mem");
        model_cnt = '0;
        bus.run = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold_state", bus.state, 3'd0);
        rst_n = 1'b1;

        // run already high: first released edge goes straight to FETCH.
        instr(7'b1110011, 0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 100; i++) begin
            step(i[0], 7'b1110011, i[1], i[2], rec(3'd6));
        end
        @(negedge clk);
        #2;
        chk("trap_sticky", bus.illegal, 1'b1);
        rst_n = 1'b0;
        #1 check_reset_state("rst_trap");
        model_cnt = '0;
        bus.run = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_step(1'b0);
        idle_step(1'b0);
        @(negedge clk);
        #1;
        chk("queue_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Port clk, input, 1: single rising-edge clock for all state.
REQ-002 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 Port run, input, 1: enable; 1 = fetch and execute instructions.
REQ-004 Port opcode, input, 7: instruction bits [6:0] from the instruction register, stable from DECODE until retire.
REQ-005 Port br_taken, input, 1: branch-condition result from the branch unit, valid in EXEC.
REQ-006 Port mem_ack, input, 1: shared data-memory grant/complete.
REQ-007 Port ir_we, output, 1: instruction-register load strobe.
REQ-008 Port pc_we, output, 1: PC update strobe.
REQ-009 Port pc_src, output, 1: PC source; 0 = PC+4, 1 = branch target.
REQ-010 Port ru_we, output, 1: register-file write strobe.
REQ-011 Port mem_req, output, 1: data-memory access request.
REQ-012 Port dm_we, output, 1: data-memory write qualifier.
REQ-013 Port instr_done, output, 1: one-cycle retire pulse.
REQ-014 Port illegal, output, 1: sticky unsupported-opcode flag.
REQ-015 Port state, output, 3: current FSM state encoding.
REQ-016 Port instr_count, output, 32: retired-instruction count (see Configuration).

Function
REQ-017 States and encodings SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; code 7 SHALL never be entered.
REQ-018 IDLE: all strobes 0; go to FETCH when run=1.
REQ-019 FETCH: ir_we=1 for exactly one cycle; go to DECODE.
REQ-020 DECODE: classify opcode and register the class: 0110011=ALU_R, 0010011=ALU_I, 0000011=LOAD, 0100011=STORE, 1100011=BRANCH; go to EXEC; any other opcode goes to TRAP.
REQ-021 EXEC transitions: ALU_R/ALU_I go to WB; LOAD/STORE go to MEM.
REQ-022 EXEC with BRANCH: assert pc_we=1 with pc_src=br_taken, pulse instr_done, then go to FETCH.
REQ-023 MEM: hold mem_req=1 (dm_we=1 for STORE) every cycle until mem_ack=1 is sampled; no timeout.
REQ-024 MEM exit: on mem_ack, LOAD goes to WB; STORE asserts pc_we=1, pc_src=0, instr_done=1 in that cycle and goes to FETCH.
REQ-025 WB: ru_we=1, pc_we=1, pc_src=0, instr_done=1 for one cycle; go to FETCH.
REQ-026 Latency in cycles FETCH-to-retire, inclusive: BRANCH 3; ALU 4; STORE 4+W; LOAD 5+W (W = cycles waiting for mem_ack).
REQ-027 run=0 mid-instruction SHALL NOT abort it; at every retire point with run=0, go to IDLE instead of FETCH.
REQ-028 mem_ack outside MEM SHALL be ignored.
REQ-029 TRAP: illegal=1, all strobes 0, no exit except reset.
REQ-030 Strobes SHALL be Moore/Mealy decodes of registered state, class and mem_ack only, with no combinational path from opcode.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, all strobes 0, illegal=0, instr_count=0 and class register=ALU_R, including during MEM with mem_req high.
REQ-032 Reset release SHALL take effect at the first clk edge with rst_n=1.

Configuration
REQ-033 Macro MC_SEQ_PERF_CNT_EN defined: instr_count increments by 1 on each instr_done and wraps 0xFFFFFFFF->0.
REQ-034 Macro MC_SEQ_PERF_CNT_EN undefined: instr_count is constant 0 and no counter flops exist.

Structure
REQ-035 Package mc_seq_pkg SHALL hold the state enum, the op-class enum and the five opcode constants.
REQ-036 The combinational opcode classifier SHALL be a sub-module mc_seq_opclass (opcode -> class, valid).

Verification
REQ-037 Reset then run=1, opcode=0110011: states 1,2,3,5,1; ru_we and pc_we high in WB only; instr_done once.
REQ-038 opcode=0000011, mem_ack held 0 for 3 MEM cycles then 1: mem_req high 4 cycles, dm_we=0, then WB with ru_we=1; 8 cycles total.
REQ-039 opcode=0100011, mem_ack=1 immediately: dm_we=mem_req=1 one cycle, pc_we=1, ru_we never 1.
REQ-040 opcode=1100011, br_taken=1: pc_we=1 and pc_src=1 in EXEC; next state FETCH.
REQ-041 opcode=1110011: TRAP, illegal=1 held 100 cycles with run toggling; rst_n pulse returns to IDLE, illegal=0.
REQ-042 run dropped in DECODE of an ALU op: instruction retires, then IDLE; with the macro defined, instr_count=N+1.
